// File: rtl/axi_mem_arbiter.sv
// Two-master AXI4 arbiter onto a single memory port. Read and write paths
// each run an independent round-robin FSM that locks one transaction at a time.
module axi_mem_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 64,
  parameter int unsigned ID_W   = 6
) (
  input  logic                clock,
  input  logic                reset,
  // requester 0
  input  logic                s0_ar_valid,
  output logic                s0_ar_ready,
  input  logic [ADDR_W-1:0]   s0_ar_addr,
  input  logic [ID_W-1:0]     s0_ar_id,
  input  logic [7:0]          s0_ar_len,
  input  logic [2:0]          s0_ar_size,
  input  logic [1:0]          s0_ar_burst,
  output logic                s0_r_valid,
  input  logic                s0_r_ready,
  output logic [DATA_W-1:0]   s0_r_data,
  output logic [ID_W-1:0]     s0_r_id,
  output logic [1:0]          s0_r_resp,
  output logic                s0_r_last,
  input  logic                s0_aw_valid,
  output logic                s0_aw_ready,
  input  logic [ADDR_W-1:0]   s0_aw_addr,
  input  logic [ID_W-1:0]     s0_aw_id,
  input  logic [7:0]          s0_aw_len,
  input  logic [2:0]          s0_aw_size,
  input  logic [1:0]          s0_aw_burst,
  input  logic                s0_w_valid,
  output logic                s0_w_ready,
  input  logic [DATA_W-1:0]   s0_w_data,
  input  logic [DATA_W/8-1:0] s0_w_strb,
  input  logic                s0_w_last,
  output logic                s0_b_valid,
  input  logic                s0_b_ready,
  output logic [ID_W-1:0]     s0_b_id,
  output logic [1:0]          s0_b_resp,
  // requester 1
  input  logic                s1_ar_valid,
  output logic                s1_ar_ready,
  input  logic [ADDR_W-1:0]   s1_ar_addr,
  input  logic [ID_W-1:0]     s1_ar_id,
  input  logic [7:0]          s1_ar_len,
  input  logic [2:0]          s1_ar_size,
  input  logic [1:0]          s1_ar_burst,
  output logic                s1_r_valid,
  input  logic                s1_r_ready,
  output logic [DATA_W-1:0]   s1_r_data,
  output logic [ID_W-1:0]     s1_r_id,
  output logic [1:0]          s1_r_resp,
  output logic                s1_r_last,
  input  logic                s1_aw_valid,
  output logic                s1_aw_ready,
  input  logic [ADDR_W-1:0]   s1_aw_addr,
  input  logic [ID_W-1:0]     s1_aw_id,
  input  logic [7:0]          s1_aw_len,
  input  logic [2:0]          s1_aw_size,
  input  logic [1:0]          s1_aw_burst,
  input  logic                s1_w_valid,
  output logic                s1_w_ready,
  input  logic [DATA_W-1:0]   s1_w_data,
  input  logic [DATA_W/8-1:0] s1_w_strb,
  input  logic                s1_w_last,
  output logic                s1_b_valid,
  input  logic                s1_b_ready,
  output logic [ID_W-1:0]     s1_b_id,
  output logic [1:0]          s1_b_resp,
  // downstream memory port
  output logic                m_ar_valid,
  input  logic                m_ar_ready,
  output logic [ADDR_W-1:0]   m_ar_addr,
  output logic [ID_W-1:0]     m_ar_id,
  output logic [7:0]          m_ar_len,
  output logic [2:0]          m_ar_size,
  output logic [1:0]          m_ar_burst,
  output logic [3:0]          m_ar_cache,
  output logic                m_ar_lock,
  output logic [2:0]          m_ar_prot,
  output logic [3:0]          m_ar_qos,
  input  logic                m_r_valid,
  output logic                m_r_ready,
  input  logic [DATA_W-1:0]   m_r_data,
  input  logic [ID_W-1:0]     m_r_id,
  input  logic [1:0]          m_r_resp,
  input  logic                m_r_last,
  output logic                m_aw_valid,
  input  logic                m_aw_ready,
  output logic [ADDR_W-1:0]   m_aw_addr,
  output logic [ID_W-1:0]     m_aw_id,
  output logic [7:0]          m_aw_len,
  output logic [2:0]          m_aw_size,
  output logic [1:0]          m_aw_burst,
  output logic [3:0]          m_aw_cache,
  output logic                m_aw_lock,
  output logic [2:0]          m_aw_prot,
  output logic [3:0]          m_aw_qos,
  output logic                m_w_valid,
  input  logic                m_w_ready,
  output logic [DATA_W-1:0]   m_w_data,
  output logic [DATA_W/8-1:0] m_w_strb,
  output logic                m_w_last,
  input  logic                m_b_valid,
  output logic                m_b_ready,
  input  logic [ID_W-1:0]     m_b_id,
  input  logic [1:0]          m_b_resp
);

  typedef enum logic [1:0] {R_IDLE = 2'd0, R_ADDR = 2'd1, R_DATA = 2'd2} r_state_e;
  typedef enum logic [1:0] {W_IDLE = 2'd0, W_ADDR = 2'd1, W_DATA = 2'd2, W_RESP = 2'd3} w_state_e;

  r_state_e r_state_q, r_state_d;
  w_state_e w_state_q, w_state_d;
  logic     rgnt_q, rgnt_d, rptr_q, rptr_d;
  logic     wgnt_q, wgnt_d, wptr_q, wptr_d;

  // handshake terms of the currently granted requester
  logic ar_valid_sel, r_ready_sel, aw_valid_sel, w_valid_sel, w_last_sel, b_ready_sel;
  assign ar_valid_sel = rgnt_q ? s1_ar_valid : s0_ar_valid;
  assign r_ready_sel  = rgnt_q ? s1_r_ready  : s0_r_ready;
  assign aw_valid_sel = wgnt_q ? s1_aw_valid : s0_aw_valid;
  assign w_valid_sel  = wgnt_q ? s1_w_valid  : s0_w_valid;
  assign w_last_sel   = wgnt_q ? s1_w_last   : s0_w_last;
  assign b_ready_sel  = wgnt_q ? s1_b_ready  : s0_b_ready;

  assign m_ar_cache = 4'b0011;
  assign m_ar_lock  = 1'b0;
  assign m_ar_prot  = 3'b000;
  assign m_ar_qos   = 4'b0000;
  assign m_aw_cache = 4'b0011;
  assign m_aw_lock  = 1'b0;
  assign m_aw_prot  = 3'b000;
  assign m_aw_qos   = 4'b0000;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state_q <= R_IDLE;
      rgnt_q    <= 1'b0;
      rptr_q    <= 1'b0;
      w_state_q <= W_IDLE;
      wgnt_q    <= 1'b0;
      wptr_q    <= 1'b0;
    end else begin
      r_state_q <= r_state_d;
      rgnt_q    <= rgnt_d;
      rptr_q    <= rptr_d;
      w_state_q <= w_state_d;
      wgnt_q    <= wgnt_d;
      wptr_q    <= wptr_d;
    end
  end

  // Read path: arbitration, AR forwarding, R routing
  always_comb begin
    r_state_d   = r_state_q;
    rgnt_d      = rgnt_q;
    rptr_d      = rptr_q;
    m_ar_valid  = 1'b0;
    m_ar_addr   = '0;
    m_ar_id     = '0;
    m_ar_len    = '0;
    m_ar_size   = '0;
    m_ar_burst  = '0;
    s0_ar_ready = 1'b0;
    s1_ar_ready = 1'b0;
    m_r_ready   = 1'b0;
    s0_r_valid  = 1'b0;
    s0_r_data   = '0;
    s0_r_id     = '0;
    s0_r_resp   = '0;
    s0_r_last   = 1'b0;
    s1_r_valid  = 1'b0;
    s1_r_data   = '0;
    s1_r_id     = '0;
    s1_r_resp   = '0;
    s1_r_last   = 1'b0;
    case (r_state_q)
      R_IDLE: begin
        if (s0_ar_valid || s1_ar_valid) begin
          rgnt_d    = (s0_ar_valid && s1_ar_valid) ? rptr_q : s1_ar_valid;
          r_state_d = R_ADDR;
        end
      end
      R_ADDR: begin
        m_ar_valid = ar_valid_sel;
        m_ar_addr  = rgnt_q ? s1_ar_addr  : s0_ar_addr;
        m_ar_id    = rgnt_q ? s1_ar_id    : s0_ar_id;
        m_ar_len   = rgnt_q ? s1_ar_len   : s0_ar_len;
        m_ar_size  = rgnt_q ? s1_ar_size  : s0_ar_size;
        m_ar_burst = rgnt_q ? s1_ar_burst : s0_ar_burst;
        if (rgnt_q) s1_ar_ready = m_ar_ready;
        else        s0_ar_ready = m_ar_ready;
        if (ar_valid_sel && m_ar_ready) r_state_d = R_DATA;
      end
      R_DATA: begin
        m_r_ready = r_ready_sel;
        if (rgnt_q) begin
          s1_r_valid = m_r_valid;
          s1_r_data  = m_r_data;
          s1_r_id    = m_r_id;
          s1_r_resp  = m_r_resp;
          s1_r_last  = m_r_last;
        end else begin
          s0_r_valid = m_r_valid;
          s0_r_data  = m_r_data;
          s0_r_id    = m_r_id;
          s0_r_resp  = m_r_resp;
          s0_r_last  = m_r_last;
        end
        if (m_r_valid && r_ready_sel && m_r_last) begin
          r_state_d = R_IDLE;
          rptr_d    = ~rgnt_q;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  // Write path: arbitration, AW and W forwarding, B routing
  always_comb begin
    w_state_d   = w_state_q;
    wgnt_d      = wgnt_q;
    wptr_d      = wptr_q;
    m_aw_valid  = 1'b0;
    m_aw_addr   = '0;
    m_aw_id     = '0;
    m_aw_len    = '0;
    m_aw_size   = '0;
    m_aw_burst  = '0;
    s0_aw_ready = 1'b0;
    s1_aw_ready = 1'b0;
    m_w_valid   = 1'b0;
    m_w_data    = '0;
    m_w_strb    = '0;
    m_w_last    = 1'b0;
    s0_w_ready  = 1'b0;
    s1_w_ready  = 1'b0;
    m_b_ready   = 1'b0;
    s0_b_valid  = 1'b0;
    s0_b_id     = '0;
    s0_b_resp   = '0;
    s1_b_valid  = 1'b0;
    s1_b_id     = '0;
    s1_b_resp   = '0;
    case (w_state_q)
      W_IDLE: begin
        if (s0_aw_valid || s1_aw_valid) begin
          wgnt_d    = (s0_aw_valid && s1_aw_valid) ? wptr_q : s1_aw_valid;
          w_state_d = W_ADDR;
        end
      end
      W_ADDR: begin
        m_aw_valid = aw_valid_sel;
        m_aw_addr  = wgnt_q ? s1_aw_addr  : s0_aw_addr;
        m_aw_id    = wgnt_q ? s1_aw_id    : s0_aw_id;
        m_aw_len   = wgnt_q ? s1_aw_len   : s0_aw_len;
        m_aw_size  = wgnt_q ? s1_aw_size  : s0_aw_size;
        m_aw_burst = wgnt_q ? s1_aw_burst : s0_aw_burst;
        if (wgnt_q) s1_aw_ready = m_aw_ready;
        else        s0_aw_ready = m_aw_ready;
        if (aw_valid_sel && m_aw_ready) w_state_d = W_DATA;
      end
      W_DATA: begin
        m_w_valid = w_valid_sel;
        m_w_data  = wgnt_q ? s1_w_data : s0_w_data;
        m_w_strb  = wgnt_q ? s1_w_strb : s0_w_strb;
        m_w_last  = w_last_sel;
        if (wgnt_q) s1_w_ready = m_w_ready;
        else        s0_w_ready = m_w_ready;
        if (w_valid_sel && m_w_ready && w_last_sel) w_state_d = W_RESP;
      end
      W_RESP: begin
        m_b_ready = b_ready_sel;
        if (wgnt_q) begin
          s1_b_valid = m_b_valid;
          s1_b_id    = m_b_id;
          s1_b_resp  = m_b_resp;
        end else begin
          s0_b_valid = m_b_valid;
          s0_b_id    = m_b_id;
          s0_b_resp  = m_b_resp;
        end
        if (m_b_valid && b_ready_sel) begin
          w_state_d = W_IDLE;
          wptr_d    = ~wgnt_q;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

endmodule

// File: doc/axi_mem_arbiter.md
# axi_mem_arbiter

Two-master AXI4 arbiter that shares the single 64-bit memory AXI port feeding the Zynq S_AXI/DDR path between two requesters, e.g. the Rocket memory port and a DMA/trace engine. It sits between the requesters and the `S_AXI_*` wires of the system block, all in the `host_clk` domain. Read and write paths are arbitrated independently, each round-robin. Each path carries one transaction at a time, locked from address handshake to final response.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 64, data width; strobe width is `DATA_W/8`
- `ID_W`, 6, AXI ID width
- `clock`  in  1  `host_clk`; all logic on the rising edge
- `reset`  in  1  asynchronous, active-high
- `sN_ar_valid`/`sN_ar_ready`  in/out  1 each  read-address handshake, N∈{0,1}
- `sN_ar_addr`/`_id`/`_len`/`_size`/`_burst`  in  ADDR_W/ID_W/8/3/2  read-address payload
- `sN_r_valid`/`sN_r_ready`  out/in  1 each  read-data handshake
- `sN_r_data`/`_id`/`_resp`/`_last`  out  DATA_W/ID_W/2/1  read-data payload
- `sN_aw_*`  same shape as `sN_ar_*`  write address
- `sN_w_valid`/`sN_w_ready`/`sN_w_data`/`sN_w_strb`/`sN_w_last`  in/out/in/in/in  1/1/DATA_W/DATA_W/8/1  write data
- `sN_b_valid`/`sN_b_ready`/`sN_b_id`/`sN_b_resp`  out/in/out/out  1/1/ID_W/2  write response
- `m_ar_*`, `m_r_*`, `m_aw_*`, `m_w_*`, `m_b_*`  mirror of the slave-side groups, opposite directions  downstream port to `S_AXI_*`
- `m_ar_cache`/`m_aw_cache`  out  4  constant 4'b0011
- `m_ar_lock`/`m_ar_prot`/`m_ar_qos` and the `aw` equivalents  out  1/3/4  constant 0

## Operation
- Read FSM: `R_IDLE` → `R_ADDR` → `R_DATA` → `R_IDLE`.
  - In `R_IDLE`, if any `sN_ar_valid` is high, register `rgnt`. If both are high, `rgnt` = `rptr` (the round-robin pointer); otherwise the single requester wins. Then go to `R_ADDR`.
  - In `R_ADDR`: `m_ar_valid = s[rgnt]_ar_valid`, `s[rgnt]_ar_ready = m_ar_ready`. On the handshake, go to `R_DATA`.
  - In `R_DATA`: `m_r` is routed to `s[rgnt]`, and `m_r_ready = s[rgnt]_r_ready`. On a handshake with `m_r_last=1`, go to `R_IDLE` and set `rptr = ~rgnt`.
- Write FSM: `W_IDLE` → `W_ADDR` → `W_DATA` → `W_RESP` → `W_IDLE`.
  - `wgnt` and `wptr` work the same way as `rgnt`/`rptr`.
  - `W_ADDR` forwards AW.
  - `W_DATA` forwards W beats and exits on a handshake with `w_last=1`.
  - `W_RESP` routes B and exits on the B handshake, updating `wptr`.
  - `s*_w_ready` stays 0 outside `W_DATA`. A requester presenting W before AW is therefore held off, which is legal AXI.
- The non-granted requester sees `ar_ready`/`aw_ready`/`w_ready` = 0 and `r_valid`/`b_valid` = 0.
- Downstream payloads are always muxed by the grant register. They are don't-care while the corresponding valid is 0.
- IDs pass through unchanged in both directions; no ID remapping.
- Read and write paths are fully independent and may serve different masters at the same time.
- The block never drops, reorders or splits beats. The burst beat count is governed only by `last`.

## Timing
- Reset values:
  - FSMs in `R_IDLE`/`W_IDLE`; `rptr`, `wptr`, `rgnt`, `wgnt` = 0.
  - All `valid`/`ready` outputs = 0; payload outputs = 0.
- Arbitration latency: a request seen in `IDLE` on cycle N gives `m_ar_valid`/`m_aw_valid` = 1 on cycle N+1.
- Address, data and response forwarding is combinational (zero added latency per beat), and ready/valid remain mutually independent as in AXI.
- Turnaround: at least one idle cycle between back-to-back transactions on the same path (the `IDLE` bubble).
- Both masters requesting continuously: grants strictly alternate. No starvation beyond one transaction.
- A master dropping `ar_valid`/`aw_valid` in `R_ADDR`/`W_ADDR` is a protocol violation. The FSM waits and does not re-arbitrate.
- Asserting `reset` mid-burst forces `IDLE` and all-zero outputs immediately. The downstream port shares the same reset, so no orphaned beats remain.

## Test plan
- Single read: `s0` issues AR addr 0x1000, len 3 → `m_ar_valid` one cycle later; four R beats delivered to `s0` only, `s1_r_valid` stays 0; return to `R_IDLE` after the last beat.
- Contention: `s0` and `s1` assert AR in the same cycle after reset → `s0` is served first, then `s1`; repeat both → grants alternate `s0`, `s1`, `s0`, `s1`.
- Write ordering: `s1` raises W (len 1, two beats, `strb` 0xFF) before AW → `w_ready` = 0 until the AW handshake; then two beats forwarded, B (id 0x2A, resp 0) returned to `s1`.
- Concurrent paths: `s0` write and `s1` read in the same cycle → both `m_aw_valid` and `m_ar_valid` are asserted on the next cycle; both complete with correct routing.
- Backpressure: hold `m_r_ready` by holding `s0_r_ready` low for 5 cycles mid-burst → no beat is lost or duplicated; data stays stable while valid is high.
- Reset mid-burst: assert `reset` during beat 2 of 8 → all valid/ready outputs go to 0 asynchronously; after release, a fresh `s1` request is granted first (`rptr` = 0 but `s0` idle).
